// File: rtl/exe_stage.sv
// exe_stage: execute stage computing ALU result, branch/jump redirect and EXE/MEM register.
// Define EXE_MUL_EN to build the iterative shift-add multiplier; otherwise MUL completes as a no-write 0.
module exe_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [34:0] control_word_in,
  input  logic [31:0] rs1_in,
  input  logic [31:0] rs2_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] pc_in,
  input  logic        stall_in,
  output logic        stall_out,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [34:0] control_word_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_data_out
);
  logic [3:0] alu_op;
  logic [2:0] funct3;
  logic b_sel_imm, a_sel_pc, branch, jal, jalr, mul, valid;
  assign alu_op    = control_word_in[3:0];
  assign b_sel_imm = control_word_in[4];
  assign a_sel_pc  = control_word_in[5];
  assign funct3    = control_word_in[11:9];
  assign branch    = control_word_in[12];
  assign jal       = control_word_in[13];
  assign jalr      = control_word_in[14];
  assign mul       = control_word_in[20];
  assign valid     = control_word_in[21];
  logic [31:0] op_a, op_b, alu_res, mul_res, result;
  logic [4:0] shamt;
  logic cond, mul_busy;
  logic [34:0] cw_cap, cw_d, cw_q;
  logic [31:0] res_d, res_q, sd_d, sd_q;
  assign op_a  = a_sel_pc ? pc_in : rs1_in;
  assign op_b  = b_sel_imm ? imm_in : rs2_in;
  assign shamt = op_b[4:0];
  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0:  alu_res = op_a + op_b;
      4'd1:  alu_res = op_a - op_b;
      4'd2:  alu_res = op_a << shamt;
      4'd3:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      4'd4:  alu_res = {31'b0, op_a < op_b};
      4'd5:  alu_res = op_a ^ op_b;
      4'd6:  alu_res = op_a >> shamt;
      4'd7:  alu_res = $signed(op_a) >>> shamt;
      4'd8:  alu_res = op_a | op_b;
      4'd9:  alu_res = op_a & op_b;
      4'd10: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000: cond = rs1_in == rs2_in;
      3'b001: cond = rs1_in != rs2_in;
      3'b100: cond = $signed(rs1_in) < $signed(rs2_in);
      3'b101: cond = $signed(rs1_in) >= $signed(rs2_in);
      3'b110: cond = rs1_in < rs2_in;
      3'b111: cond = rs1_in >= rs2_in;
      default: cond = 1'b0;
    endcase
  end
  assign redirect_pc    = jalr ? ((rs1_in + imm_in) & ~32'd1) : (pc_in + imm_in);
  assign redirect_valid = valid & (jal | jalr | (branch & cond)) & ~stall_in & ~mul_busy;
  assign stall_out      = mul_busy | stall_in;
`ifdef EXE_MUL_EN
  localparam int CNT_W = $clog2(MUL_CYCLES);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else if (!stall_in) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    case (state_q)
      IDLE: if (valid && mul) begin
        mcand_d  = op_a;
        mplier_d = op_b;
        prod_d   = '0;
        cnt_d    = '0;
        state_d  = BUSY;
      end
      BUSY: begin
        prod_d  = mplier_q[cnt_q] ? prod_q + (mcand_q << cnt_q) : prod_q;
        state_d = (cnt_q == CNT_W'(MUL_CYCLES - 1)) ? DONE : BUSY;
        cnt_d   = (cnt_q == CNT_W'(MUL_CYCLES - 1)) ? cnt_q : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign mul_busy = valid & mul & (state_q != DONE);
  assign mul_res  = prod_q;
  assign cw_cap   = control_word_in;
`else
  assign mul_busy = 1'b0;
  assign mul_res  = '0;
  assign cw_cap   = mul ? {control_word_in[34:7], 1'b0, control_word_in[5:0]} : control_word_in;
`endif
  assign result = (jal | jalr) ? pc_in + 32'd4 : mul ? mul_res : alu_res;
  always_comb begin
    cw_d  = stall_in ? cw_q  : mul_busy ? '0 : cw_cap;
    res_d = stall_in ? res_q : mul_busy ? '0 : result;
    sd_d  = stall_in ? sd_q  : mul_busy ? '0 : rs2_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cw_q  <= '0;
      res_q <= '0;
      sd_q  <= '0;
    end else begin
      cw_q  <= cw_d;
      res_q <= res_d;
      sd_q  <= sd_d;
    end
  end
  assign control_word_out = cw_q;
  assign alu_result_out   = res_q;
  assign store_data_out   = sd_q;
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: randomized and directed checks of exe_stage against a behavioural model.
module tb_exe_stage;
  logic clk = 1'b0;
  logic rst;
  logic [34:0] cw;
  logic [31:0] rs1, rs2, imm, pc;
  logic stall_in;
  logic stall_out, redirect_valid;
  logic [31:0] redirect_pc, alu_result_out, store_data_out;
  logic [34:0] control_word_out;
  int n_vec = 0;
  int n_err = 0;
  logic [34:0] e_cw;
  logic [31:0] e_res, e_sd;

  exe_stage dut (
    .clk(clk), .rst(rst), .control_word_in(cw), .rs1_in(rs1), .rs2_in(rs2), .imm_in(imm),
    .pc_in(pc), .stall_in(stall_in), .stall_out(stall_out), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .control_word_out(control_word_out),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] mk(input logic [3:0] op, input logic bimm, input logic apc,
                                     input logic [2:0] f3, input logic br, input logic j,
                                     input logic jr, input logic m, input logic v);
    logic [34:0] w;
    w = '0;
    w[3:0] = op; w[4] = bimm; w[5] = apc; w[6] = 1'b1; w[11:9] = f3;
    w[12] = br; w[13] = j; w[14] = jr; w[19:15] = 5'd3; w[20] = m; w[21] = v;
    return w;
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return 32'(int'(a) >>> sh);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_take(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) < int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; stall_in = 1'b0;
    cw = mk(4'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rs1 = 32'h11; rs2 = 32'h22; imm = 32'h33; pc = 32'h44;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (control_word_out !== 35'd0) begin n_err++; $display("FAIL reset_cw got %h exp 0", control_word_out); end
    n_vec++; if (alu_result_out !== 32'd0) begin n_err++; $display("FAIL reset_res got %h exp 0", alu_result_out); end
    n_vec++; if (store_data_out !== 32'd0) begin n_err++; $display("FAIL reset_sd got %h exp 0", store_data_out); end
    n_vec++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", stall_out); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    cw = mk(4'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rs1 = 32'd5; imm = 32'd7; rs2 = 32'h99;
    #1;
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL add_redir got %b exp 0", redirect_valid); end
    @(posedge clk); #1;
    n_vec++; if (alu_result_out !== 32'd12) begin n_err++; $display("FAIL add_res got %0d exp 12", alu_result_out); end
    n_vec++; if (control_word_out !== cw) begin n_err++; $display("FAIL add_cw got %h exp %h", control_word_out, cw); end
    n_vec++; if (store_data_out !== 32'h99) begin n_err++; $display("FAIL add_sd got %h exp 99", store_data_out); end
  endtask

  task automatic test_branch();
    cw = mk(4'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    rs1 = 32'd3; rs2 = 32'd3; pc = 32'h100; imm = 32'h20;
    #1;
    n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL beq_taken got %b exp 1", redirect_valid); end
    n_vec++; if (redirect_pc !== 32'h120) begin n_err++; $display("FAIL beq_pc got %h exp 120", redirect_pc); end
    @(posedge clk); #1;
    rs2 = 32'd4;
    #1;
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL beq_not_taken got %b exp 0", redirect_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_jalr();
    cw = mk(4'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    rs1 = 32'h2001; imm = 32'd4; pc = 32'h40;
    #1;
    n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL jalr_valid got %b exp 1", redirect_valid); end
    n_vec++; if (redirect_pc !== 32'h2004) begin n_err++; $display("FAIL jalr_pc got %h exp 2004", redirect_pc); end
    @(posedge clk); #1;
    n_vec++; if (alu_result_out !== 32'h44) begin n_err++; $display("FAIL jalr_res got %h exp 44", alu_result_out); end
  endtask

  task automatic test_random(input int iters);
    logic [34:0] w;
    logic exp_red;
    logic [31:0] exp_pc, a, b;
    int kind;
    for (int i = 0; i < iters; i++) begin
      kind = int'($urandom_range(0, 3));
      w = mk(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 3'($urandom),
             kind == 1, kind == 2, kind == 3, 1'b0, $urandom_range(0, 9) != 0);
      w[34:22] = 13'($urandom); w[19:15] = 5'($urandom); w[8:6] = 3'($urandom);
      cw = w; rs1 = $urandom; imm = $urandom; pc = $urandom & ~32'd3;
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      stall_in = (i != 0) && ($urandom_range(0, 4) == 0);
      #1;
      exp_red = w[21] && (kind == 2 || kind == 3 || (kind == 1 && m_take(w[11:9], rs1, rs2))) && !stall_in;
      exp_pc = (kind == 3) ? ((rs1 + imm) & ~32'd1) : pc + imm;
      n_vec++; if (redirect_valid !== exp_red) begin n_err++; $display("FAIL rnd_redir[%0d] got %b exp %b", i, redirect_valid, exp_red); end
      if (exp_red) begin
        n_vec++; if (redirect_pc !== exp_pc) begin n_err++; $display("FAIL rnd_pc[%0d] got %h exp %h", i, redirect_pc, exp_pc); end
      end
      n_vec++; if (stall_out !== stall_in) begin n_err++; $display("FAIL rnd_stall[%0d] got %b exp %b", i, stall_out, stall_in); end
      if (!stall_in) begin
        a = w[5] ? pc : rs1;
        b = w[4] ? imm : rs2;
        e_cw = w; e_sd = rs2;
        e_res = (kind >= 2) ? pc + 32'd4 : m_alu(w[3:0], a, b);
      end
      @(posedge clk); #1;
      n_vec++; if (control_word_out !== e_cw) begin n_err++; $display("FAIL rnd_cw[%0d] got %h exp %h", i, control_word_out, e_cw); end
      n_vec++; if (alu_result_out !== e_res) begin n_err++; $display("FAIL rnd_res[%0d] got %h exp %h", i, alu_result_out, e_res); end
      n_vec++; if (store_data_out !== e_sd) begin n_err++; $display("FAIL rnd_sd[%0d] got %h exp %h", i, store_data_out, e_sd); end
    end
    stall_in = 1'b0;
  endtask

  task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input int sa, input int sl);
    logic [34:0] w;
    logic [31:0] prod;
    int hi;
    bit done;
    w = mk(4'($urandom_range(0, 10)), 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cw = w; rs1 = a; rs2 = b; imm = $urandom; pc = $urandom;
    prod = a * b;
`ifdef EXE_MUL_EN
    hi = 0; done = 0;
    for (int c = 0; c < 80 && !done; c++) begin
      stall_in = (c >= sa) && (c < sa + sl);
      #1;
      n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL mul_redir[%0d] got %b exp 0", c, redirect_valid); end
      if (stall_out) begin
        hi++;
        @(posedge clk); #1;
        n_vec++; if (control_word_out !== 35'd0 || alu_result_out !== 32'd0) begin
          n_err++; $display("FAIL mul_bubble[%0d] got cw=%h res=%h exp 0", c, control_word_out, alu_result_out);
        end
      end else begin
        @(posedge clk); #1;
        done = 1;
        n_vec++; if (alu_result_out !== prod) begin n_err++; $display("FAIL mul_prod got %h exp %h", alu_result_out, prod); end
        n_vec++; if (control_word_out !== w) begin n_err++; $display("FAIL mul_cw got %h exp %h", control_word_out, w); end
      end
    end
    n_vec++; if (!done || hi != 33 + sl) begin n_err++; $display("FAIL mul_stall_cycles got %0d done=%0d exp %0d", hi, done, 33 + sl); end
`else
    stall_in = 1'b0;
    #1;
    n_vec++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL mul_stall got %b exp 0", stall_out); end
    @(posedge clk); #1;
    w[6] = 1'b0;
    n_vec++; if (alu_result_out !== 32'd0) begin n_err++; $display("FAIL mul_res got %h exp 0", alu_result_out); end
    n_vec++; if (control_word_out !== w) begin n_err++; $display("FAIL mul_cw got %h exp %h", control_word_out, w); end
    if (sa < 0) $display("unused %0d %0d %h", sa, sl, prod);
`endif
    stall_in = 1'b0;
    cw = '0;
  endtask

  task automatic test_mul_reset();
    cw = mk(4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    rs1 = 32'd9; rs2 = 32'd11;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (control_word_out !== 35'd0 || alu_result_out !== 32'd0 || store_data_out !== 32'd0) begin
      n_err++; $display("FAIL mulrst_out got cw=%h res=%h sd=%h exp 0", control_word_out, alu_result_out, store_data_out);
    end
    cw = mk(4'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rs1 = 32'd100; imm = 32'd23;
    #1;
    n_vec++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL mulrst_stall got %b exp 0", stall_out); end
    @(posedge clk); #1;
    n_vec++; if (alu_result_out !== 32'd123) begin n_err++; $display("FAIL mulrst_add got %0d exp 123", alu_result_out); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_jalr();
    test_random(300);
    test_mul(32'd7, 32'd6, 100, 0);
    test_mul(32'hFFFFFFFF, 32'd2, 100, 0);
    test_mul($urandom, $urandom, 12, 3);
    test_mul($urandom, $urandom, 100, 0);
    test_mul_reset();
    test_mul($urandom, $urandom, 100, 0);
    test_random(100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
Execute stage sitting between the ID/EXE pipeline register and the MEM stage. It consumes the registered control word, operands, immediate and PC, and computes the ALU result, branch/jump decision and redirect target. Results are registered into the EXE/MEM boundary. A 32-cycle iterative multiplier stalls the front end while it runs.

Parameters:
MUL_CYCLES, 32, number of BUSY iterations of the shift-add multiplier; must equal the operand width.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
control_word_in  in  35  control word from ID/EXE (field map in Behaviour)
rs1_in  in  32  source operand 1
rs2_in  in  32  source operand 2 / store data
imm_in  in  32  sign-extended immediate
pc_in  in  32  PC of the instruction in EXE
stall_in  in  1  MEM stage hold request
stall_out  out  1  hold request to ID/EXE and upstream stages
redirect_valid  out  1  taken branch/jump; upstream flushes IF/ID and ID/EXE and loads redirect_pc
redirect_pc  out  32  redirect target
control_word_out  out  35  registered control word to MEM
alu_result_out  out  32  registered result (ALU, product, or PC+4 for JAL/JALR)
store_data_out  out  32  registered rs2

Behaviour:
- Control word fields: [3:0] alu_op; [4] b_sel_imm; [5] a_sel_pc; [6] reg_write; [7] mem_read; [8] mem_write; [11:9] funct3; [12] branch; [13] jal; [14] jalr; [19:15] rd; [20] mul; [21] valid; [34:22] pass-through.
- Operand A = a_sel_pc ? pc_in : rs1_in. Operand B = b_sel_imm ? imm_in : rs2_in.
- alu_op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B. Codes 11-15 give 0. Shifts use B[4:0]. All arithmetic is modulo 2^32.
- Branch condition on rs1_in/rs2_in by funct3: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU. Codes 010/011 are never taken.
- Targets: branch/jal use pc_in+imm_in. jalr uses (rs1_in+imm_in) with bit 0 cleared.
- redirect_valid = valid & (jal | jalr | (branch & cond)) & ~stall_in & ~mul_busy. It is combinational, in the cycle the instruction is in EXE.
- JAL/JALR: alu_result = pc_in+4.
- Multiplier FSM, states IDLE/BUSY/DONE:
  - IDLE: when valid & mul & ~stall_in, latch A and B, clear the product, cnt=0, go to BUSY.
  - BUSY: each cycle, if multiplier bit cnt is set, add the multiplicand shifted left by cnt. After cnt=MUL_CYCLES-1, go to DONE.
  - DONE: the product's low 32 bits are captured into EXE/MEM, then the FSM returns to IDLE.
  - mul_busy = valid & mul & (state != DONE). A MUL therefore occupies EXE for MUL_CYCLES+2 cycles, with mul_busy high for MUL_CYCLES+1 of them.
- stall_out = mul_busy | stall_in.
- EXE/MEM register update:
  - rst: all outputs 0.
  - else if stall_in: hold all outputs and the FSM state.
  - else if mul_busy: insert a bubble (control_word_out=0, other outputs 0).
  - else: capture the control word, the result and rs2_in.
- An instruction with valid=0 passes through with no redirect and no FSM start.
- Reset values: all registered outputs 0, FSM IDLE, cnt 0. Reset during BUSY aborts the multiply; the next cycle is IDLE with no stall.
- When stall_in and mul_busy are both high, stall_in dominates: the FSM freezes and the outputs hold.

Optional Feature:
- Macro: EXE_MUL_EN.
- Defined: the multiplier FSM exists as specified.
- Undefined: no FSM. mul_busy is tied to 0, and a mul instruction completes in one cycle with alu_result_out=0 and reg_write cleared in control_word_out.

Test Plan:
- ADD: rs1=5, imm=7, b_sel_imm=1, alu_op=0 -> next cycle alu_result_out=12, control_word_out=input word.
- BEQ taken: rs1=rs2=3, pc=0x100, imm=0x20 -> redirect_valid=1, redirect_pc=0x120 the same cycle. With rs2=4 -> redirect_valid=0.
- JALR: rs1=0x2001, imm=4, pc=0x40 -> redirect_pc=0x2004, alu_result_out=0x44.
- MUL 7*6 (EXE_MUL_EN) -> stall_out high 33 cycles, bubbles output throughout; alu_result_out=42 in the cycle after DONE. 0xFFFFFFFF*2 -> 0xFFFFFFFE.
- stall_in asserted mid-BUSY for 3 cycles -> outputs held and cnt frozen; the product is still correct and appears 3 cycles later.
- rst pulsed at BUSY cnt=10 -> all outputs 0, stall_out=0 the next cycle; a following ADD completes normally.
